// File: rtl/uart_tx_if.sv
// Host-side byte queue port for uart_tx.
//   din        byte offered by the host
//   din_valid  din offered this cycle
//   din_ready  transmitter FIFO not full
// master = host side, slave = uart_tx side.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/uart_tx.sv
// Hardwired UART transmitter, serialising queued bytes as 8N1 (configurable)
// on one line. Bit timing is derived from a 16.8 fractional divider in the same
// format as the PIO state machines, CYCLES_PER_BIT divided ticks per bit.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   en           1 = divider runs, 0 = pause (all state held)
//   div          [23:8] integer, [7:0] fraction; integer 0 -> tick every clk
//   host         byte queue port (din / din_valid / din_ready)
//   tx           serial line, idle high
//   busy         frame in progress or FIFO non-empty
//   fifo_level   entries queued
module uart_tx #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned CYCLES_PER_BIT = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [23:0]                   div,
  uart_tx_if.slave                      host,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TCNT_W = $clog2(STOP_BITS * CYCLES_PER_BIT + 1);
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TCNT_W-1:0] LAST_BIT_T  = TCNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [TCNT_W-1:0] LAST_STOP_T = TCNT_W'(STOP_BITS * CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_BITS - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL    = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- fractional tick generator ----------------
  logic [15:0] div_int;
  logic [7:0]  div_frac;
  logic [15:0] cnt_q;
  logic [7:0]  acc_q;
  logic [8:0]  acc_sum;
  logic        tick_c;

  assign div_int  = div[23:8];
  assign div_frac = div[7:0];

  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, div_frac};
    tick_c  = en && ((div_int == 16'd0) || (cnt_q == 16'd0));
  end

  // Tick when the counter is zero; reload with int + carry - 1 so the period
  // stretches by one clk whenever the fraction accumulator overflows.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
      acc_q <= 8'd0;
    end else if (en) begin
      if (div_int == 16'd0) begin
        cnt_q <= 16'd0;
      end else if (cnt_q == 16'd0) begin
        acc_q <= acc_sum[7:0];
        cnt_q <= div_int + 16'(acc_sum[8]) - 16'd1;
      end else begin
        cnt_q <= cnt_q - 16'd1;
      end
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 pop_c;
  logic                 push_c;
  logic                 empty_c;
  logic                 full_c;
  logic [LVL_W-1:0]     level_d;

  // A write arriving while full is still taken if a pop frees a slot this cycle.
  always_comb begin
    empty_c = (fifo_level == '0);
    full_c  = (fifo_level == FULL_LVL);
    push_c  = host.din_valid && (!full_c || pop_c);
    level_d = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= host.din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_d;
    end
  end

  // ---------------- frame FSM ----------------
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 tx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      tcnt_q         <= '0;
      bit_q          <= '0;
      tx             <= 1'b1;
      busy           <= 1'b0;
      host.din_ready <= 1'b1;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      tcnt_q         <= tcnt_d;
      bit_q          <= bit_d;
      tx             <= tx_d;
      busy           <= (state_d != IDLE) || (level_d != '0);
      host.din_ready <= (level_d != FULL_LVL);
    end
  end

  // Everything advances on divider ticks only; tx_d is the line value for the
  // state being entered, so tx changes exactly on the tick edge.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    tx_d    = tx;
    pop_c   = 1'b0;
    if (tick_c) begin
      case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_d = mem[rd_ptr];
            tcnt_d  = '0;
            state_d = START;
            tx_d    = 1'b0;
          end
        end
        START: begin
          if (tcnt_q == LAST_BIT_T) begin
            tcnt_d  = '0;
            bit_d   = '0;
            state_d = DATA;
            tx_d    = shift_q[0];
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        DATA: begin
          if (tcnt_q == LAST_BIT_T) begin
            tcnt_d = '0;
            if (bit_q == LAST_BIT) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shift_d = shift_q >> 1;
              tx_d    = shift_d[0];
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        STOP: begin
          if (tcnt_q == LAST_STOP_T) begin
            tcnt_d = '0;
            // Back-to-back frames: go straight to the next start bit.
            if (!empty_c) begin
              pop_c   = 1'b1;
              shift_d = mem[rd_ptr];
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

endmodule
